// File: rtl/serial_rx_byte.sv
// ---------------------------------------------------------------------------
// serial_rx_byte
//
// Asynchronous 8N1 serial receiver, LSB first. It recovers bytes from a
// single idle-high line and hands each good byte to the downstream 4-byte
// queue: `data` feeds the queue data input and `EN` is the one-cycle push
// strobe. A frame whose stop bit samples low raises `frame_err` for one
// cycle. Such a frame is never pushed.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (legal range 4..65535).
//                  H = CLKS_PER_BIT/2 is the mid-bit offset.
//
// Ports
//   clk       in   system clock, rising-edge
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial line, idle high
//   data      out  [7:0] last correctly received byte (holds between pushes)
//   EN        out  one-cycle pulse when data carries a new byte
//   frame_err out  one-cycle pulse when the stop bit is sampled low
//   busy      out  high whenever the receiver is not idle
//
// Timing (d = first IDLE cycle in which the synchronised line reads 0)
//   start sampled at d+H, data bit k at d+H+(k+1)*CLKS_PER_BIT,
//   stop at d+H+9*CLKS_PER_BIT, EN / frame_err at d+H+9*CLKS_PER_BIT+1.
// ---------------------------------------------------------------------------
module serial_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       EN,
  output logic       frame_err,
  output logic       busy
);

  // Terminal counts of the cycle counter. The start bit is checked at its
  // middle, and each later bit one full bit period after the previous sample.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 32'd1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 32'd2) - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  // Synchroniser stages. The second stage is the only view of the line.
  logic        sync1_q;
  logic        sync2_q;
  logic        rx_s;

  state_e      state_q,   state_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [7:0]  data_q,    data_d;
  logic        en_q,      en_d;
  logic        ferr_q,    ferr_d;
  logic        busy_q,    busy_d;

  assign rx_s = sync2_q;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cyc_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      en_q      <= en_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: frame sequencing, bit sampling and pulse generation.
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    en_d      = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The cycle counter is held at zero so that START counts from the
        // detection cycle.
        cyc_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
        if (rx_s == 1'b0) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (cyc_cnt_q == HALF_LAST) begin
          cyc_cnt_d = 16'd0;
          bit_cnt_d = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          if (rx_s == 1'b0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = 16'd0;
          // Shift right so that the first bit received ends up in bit 0.
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end

      ST_STOP: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = 16'd0;
          if (rx_s == 1'b1) begin
            // Return to IDLE at mid-stop. This leaves half a bit of margin
            // for a fast transmitter's next start edge.
            data_d  = shift_q;
            en_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end

      ST_WAIT_HIGH: begin
        // The receiver stays here through a break, so a held-low line
        // yields only one error.
        cyc_cnt_d = 16'd0;
        if (rx_s == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cyc_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
      end
    endcase

    // busy is registered from the next state. It therefore rises one cycle
    // after detection and falls in the first IDLE cycle.
    if (state_d != ST_IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  assign data      = data_q;
  assign EN        = en_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_rx_byte.sv
module tb_serial_rx_byte;

  logic       clk = 1'b0;
  logic       rst16, rx16, en16, fe16, busy16;
  logic [7:0] data16;
  logic       rst4, rx4, en4, fe4, busy4;
  logic [7:0] data4;

  int vectors_applied = 0;
  int miscompares     = 0;
  int cyc             = 0;

  // Pulse logs for each DUT (cycle stamp + data), and a downstream queue model.
  int         en16_cyc[$];
  logic [7:0] en16_dat[$];
  int         fe16_cyc[$];
  int         en4_cyc[$];
  logic [7:0] en4_dat[$];
  int         fe4_cyc[$];
  logic [31:0] q32 = 32'h0;

  typedef struct {
    int         sel;       // 0: CLKS_PER_BIT=16 instance, 1: CLKS_PER_BIT=4
    logic [7:0] value;
    logic       stop_bit;
    int         hold_low;  // extra cycles the line stays low after the frame
    logic       exp_en;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  serial_rx_byte #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst16), .rx(rx16), .data(data16),
    .EN(en16), .frame_err(fe16), .busy(busy16)
  );

  serial_rx_byte #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .rx(rx4), .data(data4),
    .EN(en4), .frame_err(fe4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en16) begin
      en16_cyc.push_back(cyc);
      en16_dat.push_back(data16);
      q32 = {q32[23:0], data16};
    end
    if (fe16) fe16_cyc.push_back(cyc);
    if (en4) begin
      en4_cyc.push_back(cyc);
      en4_dat.push_back(data4);
    end
    if (fe4) fe4_cyc.push_back(cyc);
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive one 8N1 frame; st returns the cycle in which the start edge was driven.
  task automatic send(input int sel, input logic [7:0] b, input logic stopv, output int st);
    logic [9:0] bits;
    int         c;
    bits = {stopv, b, 1'b0};
    c    = (sel == 0) ? 16 : 4;
    st   = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sel == 0) rx16 = bits[i]; else rx4 = bits[i];
      if (i == 0) st = cyc;
      repeat (c - 1) @(posedge clk);
    end
  endtask

  initial begin
    int st, st0, c, base_en, base_fe, n_en, n_fe, act_c, exp_c;
    logic [7:0] act_d;
    logic [7:0] b2b [4];

    vecs[0] = '{0, 8'hA5, 1'b1, 0,   1'b1, 8'hA5, 1'b0};
    vecs[1] = '{0, 8'h3C, 1'b0, 300, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{0, 8'h5A, 1'b1, 0,   1'b1, 8'h5A, 1'b0};
    vecs[3] = '{1, 8'h00, 1'b1, 0,   1'b1, 8'h00, 1'b0};
    vecs[4] = '{1, 8'hFF, 1'b1, 0,   1'b1, 8'hFF, 1'b0};
    vecs[5] = '{1, 8'h81, 1'b0, 50,  1'b0, 8'hFF, 1'b1};
    vecs[6] = '{1, 8'h6B, 1'b1, 0,   1'b1, 8'h6B, 1'b0};
    b2b = '{8'h11, 8'h22, 8'h33, 8'h44};

    rx16 = 1'b1; rx4 = 1'b1; rst16 = 1'b1; rst4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data16", data16, 8'h00);
    check("rst_en16",   en16,   1'b0);
    check("rst_ferr16", fe16,   1'b0);
    check("rst_busy16", busy16, 1'b0);
    check("rst_data4",  data4,  8'h00);
    check("rst_busy4",  busy4,  1'b0);
    rst16 = 1'b0; rst4 = 1'b0;
    repeat (4) @(posedge clk);

    // Table-driven frames on both instances.
    for (int v = 0; v < 7; v++) begin
      c       = (vecs[v].sel == 0) ? 16 : 4;
      base_en = (vecs[v].sel == 0) ? en16_cyc.size() : en4_cyc.size();
      base_fe = (vecs[v].sel == 0) ? fe16_cyc.size() : fe4_cyc.size();
      send(vecs[v].sel, vecs[v].value, vecs[v].stop_bit, st);
      if (vecs[v].hold_low > 0) begin
        repeat (vecs[v].hold_low) @(posedge clk);
        #1;
        if (vecs[v].sel == 0) rx16 = 1'b1; else rx4 = 1'b1;
      end
      repeat (3 * c) @(posedge clk);
      @(negedge clk);
      exp_c = st + 2 + c / 2 + 9 * c + 1;
      n_en  = ((vecs[v].sel == 0) ? en16_cyc.size() : en4_cyc.size()) - base_en;
      n_fe  = ((vecs[v].sel == 0) ? fe16_cyc.size() : fe4_cyc.size()) - base_fe;
      check($sformatf("v%0d_en_count", v), n_en, vecs[v].exp_en);
      check($sformatf("v%0d_ferr_count", v), n_fe, vecs[v].exp_ferr);
      if (vecs[v].exp_en) begin
        act_c = (n_en > 0) ? ((vecs[v].sel == 0) ? en16_cyc[base_en] : en4_cyc[base_en]) : -1;
        act_d = (n_en > 0) ? ((vecs[v].sel == 0) ? en16_dat[base_en] : en4_dat[base_en]) : 8'hxx;
        check($sformatf("v%0d_en_cycle", v), act_c, exp_c);
        check($sformatf("v%0d_en_data", v), act_d, vecs[v].exp_data);
      end
      if (vecs[v].exp_ferr) begin
        act_c = (n_fe > 0) ? ((vecs[v].sel == 0) ? fe16_cyc[base_fe] : fe4_cyc[base_fe]) : -1;
        check($sformatf("v%0d_ferr_cycle", v), act_c, exp_c);
      end
      check($sformatf("v%0d_data_hold", v), (vecs[v].sel == 0) ? data16 : data4, vecs[v].exp_data);
      check($sformatf("v%0d_busy_idle", v), (vecs[v].sel == 0) ? busy16 : busy4, 1'b0);
    end

    // Back-to-back frames into the downstream queue.
    base_en = en16_cyc.size();
    st0 = 0;
    for (int k = 0; k < 4; k++) begin
      send(0, b2b[k], 1'b1, st);
      if (k == 0) st0 = st;
    end
    repeat (48) @(posedge clk);
    @(negedge clk);
    check("b2b_en_count", en16_cyc.size() - base_en, 4);
    for (int k = 0; k < 4; k++) begin
      act_c = (en16_cyc.size() > base_en + k) ? en16_cyc[base_en + k] : -1;
      act_d = (en16_dat.size() > base_en + k) ? en16_dat[base_en + k] : 8'hxx;
      check($sformatf("b2b%0d_cycle", k), act_c, st0 + 155 + 160 * k);
      check($sformatf("b2b%0d_data", k), act_d, b2b[k]);
    end
    check("b2b_queue", q32, 32'h11223344);

    // Four-cycle glitch while idle: false start, no output activity.
    base_en = en16_cyc.size();
    base_fe = fe16_cyc.size();
    @(posedge clk); #1;
    rx16 = 1'b0;
    st = cyc;
    wait_cyc(st + 3);
    check("glitch_busy_d1", busy16, 1'b1);
    @(posedge clk); #1;
    rx16 = 1'b1;
    wait_cyc(st + 11);
    check("glitch_busy_d9", busy16, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_no_en", en16_cyc.size() - base_en, 0);
    check("glitch_no_ferr", fe16_cyc.size() - base_fe, 0);

    // Reset in the middle of a frame (0xF3; bits 4..7 and the stop bit are high).
    base_en = en16_cyc.size();
    base_fe = fe16_cyc.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rx16 = (i == 0) ? 1'b0 : ((i == 3 || i == 4) ? 1'b0 : 1'b1);
      repeat (15) @(posedge clk);
    end
    @(posedge clk); #1;
    rx16 = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    @(negedge clk);
    check("midrst_data", data16, 8'h00);
    check("midrst_en", en16, 1'b0);
    check("midrst_busy", busy16, 1'b0);
    repeat (96) @(posedge clk);
    @(negedge clk);
    check("midrst_no_en", en16_cyc.size() - base_en, 0);
    check("midrst_no_ferr", fe16_cyc.size() - base_fe, 0);

    base_en = en16_cyc.size();
    send(0, 8'hFF, 1'b1, st);
    repeat (48) @(posedge clk);
    @(negedge clk);
    check("postrst_en_count", en16_cyc.size() - base_en, 1);
    act_c = (en16_cyc.size() > base_en) ? en16_cyc[base_en] : -1;
    check("postrst_en_cycle", act_c, st + 155);
    check("postrst_data", data16, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
